// File: rtl/proc_defs.sv
// Shared definitions for the image-filter pipeline writeback stage.
package proc_defs;

  localparam int unsigned LANES      = 5;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_W      = 4;
  localparam int unsigned LANE_IDX_W = 3;

  typedef enum logic {
    StIdle = 1'b0,
    StVec  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/lane_serializer.sv
// Latches a vector result and emits it one lane per cycle, lane 0 first.
module lane_serializer #(
  parameter int unsigned LANES  = proc_defs::LANES,
  parameter int unsigned LANE_W = proc_defs::LANE_W,
  parameter int unsigned IDX_W  = proc_defs::LANE_IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    advance,
  input  logic [LANES*LANE_W-1:0] vec_in,
  output logic [LANE_W-1:0]       lane_data,
  output logic [IDX_W-1:0]        lane_idx,
  output logic                    we,
  output logic                    last
);

  logic [LANES*LANE_W-1:0] vec_q;
  logic [IDX_W-1:0]        lane_q;
  logic [IDX_W-1:0]        lane_nxt;
  logic [LANE_W-1:0]       data_q;
  logic                    we_q;

  assign lane_nxt = lane_q + 1'b1;
  assign last     = (lane_q == IDX_W'(LANES - 1));

  // Load shows lane 0 next cycle; advance steps to the following lane; otherwise park at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q  <= '0;
      lane_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
    end else if (load) begin
      vec_q  <= vec_in;
      lane_q <= '0;
      data_q <= vec_in[LANE_W-1:0];
      we_q   <= 1'b1;
    end else if (advance) begin
      lane_q <= lane_nxt;
      data_q <= vec_q[int'(lane_nxt)*LANE_W +: LANE_W];
      we_q   <= 1'b1;
    end else begin
      lane_q <= '0;
      we_q   <= 1'b0;
    end
  end

  assign lane_data = data_q;
  assign lane_idx  = lane_q;
  assign we        = we_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: scalar results in one cycle, vector results serialised lane by lane.
module writeback_unit #(
  parameter int unsigned LANES  = proc_defs::LANES,
  parameter int unsigned LANE_W = proc_defs::LANE_W,
  parameter int unsigned DATA_W = proc_defs::DATA_W,
  parameter int unsigned REG_W  = proc_defs::REG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_wb_en,
  input  logic                    in_is_vec,
  input  logic                    in_sel_mem,
  input  logic [DATA_W-1:0]       in_alu_res,
  input  logic [DATA_W-1:0]       in_mem_res,
  input  logic [LANES*LANE_W-1:0] in_vec_res,
  input  logic [REG_W-1:0]        in_rd,
  output logic [REG_W-1:0]        Rg_WB,
  output logic [DATA_W-1:0]       DinC,
  output logic                    WE_C,
  output logic [LANE_W-1:0]       DinV_8bit,
  output logic                    WE_V,
  output logic [2:0]              lane_idx,
  output logic                    wb_busy,
  output logic [REG_W-1:0]        wb_rd
);

  import proc_defs::*;

  wb_state_e         state_q, state_d;
  logic              last;
  logic              xfer;
  logic              vec_start;
  logic              scalar_wr;
  logic              advance;
  logic              we_c_q;
  logic [DATA_W-1:0] dinc_q;
  logic [REG_W-1:0]  rg_q;
  logic [REG_W-1:0]  wb_rd_q;

  // Ready depends only on state and lane position, never on in_valid.
  assign in_ready  = (state_q == StIdle) || ((state_q == StVec) && last);
  assign xfer      = in_valid && in_ready;
  assign vec_start = xfer && in_is_vec && in_wb_en;
  assign scalar_wr = xfer && !in_is_vec && in_wb_en;
  assign advance   = (state_q == StVec) && !last;

  // Next-state: enter VEC on a written vector; leave after the last lane unless a new one arrives.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (vec_start) state_d = StVec;
      StVec:  if (last) state_d = vec_start ? StVec : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Scalar write port and shared write address; data and address hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_c_q  <= 1'b0;
      dinc_q  <= '0;
      rg_q    <= '0;
      wb_rd_q <= '0;
    end else begin
      we_c_q <= scalar_wr;
      if (scalar_wr) dinc_q <= in_sel_mem ? in_mem_res : in_alu_res;
      if (scalar_wr || vec_start) rg_q <= in_rd;
      if (vec_start) wb_rd_q <= in_rd;
    end
  end

  lane_serializer #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .IDX_W  (3)
  ) u_lane_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (vec_start),
    .advance   (advance),
    .vec_in    (in_vec_res),
    .lane_data (DinV_8bit),
    .lane_idx  (lane_idx),
    .we        (WE_V),
    .last      (last)
  );

  assign WE_C    = we_c_q;
  assign DinC    = dinc_q;
  assign Rg_WB   = rg_q;
  assign wb_rd   = wb_rd_q;
  assign wb_busy = (state_q == StVec);

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: vector table, hand-written corner sequences, random traffic.
module tb_writeback_unit;

  localparam int unsigned LANES  = 5;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_wb_en;
  logic                    in_is_vec;
  logic                    in_sel_mem;
  logic [DATA_W-1:0]       in_alu_res;
  logic [DATA_W-1:0]       in_mem_res;
  logic [LANES*LANE_W-1:0] in_vec_res;
  logic [REG_W-1:0]        in_rd;
  logic [REG_W-1:0]        Rg_WB;
  logic [DATA_W-1:0]       DinC;
  logic                    WE_C;
  logic [LANE_W-1:0]       DinV_8bit;
  logic                    WE_V;
  logic [2:0]              lane_idx;
  logic                    wb_busy;
  logic [REG_W-1:0]        wb_rd;

  writeback_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wb_en   (in_wb_en),
    .in_is_vec  (in_is_vec),
    .in_sel_mem (in_sel_mem),
    .in_alu_res (in_alu_res),
    .in_mem_res (in_mem_res),
    .in_vec_res (in_vec_res),
    .in_rd      (in_rd),
    .Rg_WB      (Rg_WB),
    .DinC       (DinC),
    .WE_C       (WE_C),
    .DinV_8bit  (DinV_8bit),
    .WE_V       (WE_V),
    .lane_idx   (lane_idx),
    .wb_busy    (wb_busy),
    .wb_rd      (wb_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected registered outputs plus the queue of lanes still to be written.
  logic              m_we_c;
  logic [31:0]       m_dinc;
  logic [3:0]        m_rg;
  logic [3:0]        m_wbrd;
  logic              m_we_v;
  logic [7:0]        m_dinv;
  int                m_lane;
  logic [7:0]        rem_d[$];
  int                rem_i[$];

  function automatic logic m_ready();
    return !m_we_v || (rem_d.size() == 0);
  endfunction

  task automatic model_reset();
    m_we_c = 0; m_dinc = 0; m_rg = 0; m_wbrd = 0;
    m_we_v = 0; m_dinv = 0; m_lane = 0;
    rem_d.delete();
    rem_i.delete();
  endtask

  task automatic model_check();
    check("in_ready", 64'(in_ready), 64'(m_ready()));
    check("WE_C", 64'(WE_C), 64'(m_we_c));
    check("DinC", 64'(DinC), 64'(m_dinc));
    check("Rg_WB", 64'(Rg_WB), 64'(m_rg));
    check("WE_V", 64'(WE_V), 64'(m_we_v));
    check("DinV_8bit", 64'(DinV_8bit), 64'(m_dinv));
    if (m_we_v) check("lane_idx", 64'(lane_idx), 64'(m_lane));
    check("wb_busy", 64'(wb_busy), 64'(m_we_v));
    check("wb_rd", 64'(wb_rd), 64'(m_wbrd));
  endtask

  task automatic model_update();
    logic xfer;
    xfer   = in_valid && m_ready();
    m_we_c = 0;
    if (m_we_v && rem_d.size() > 0) begin
      m_dinv = rem_d.pop_front();
      m_lane = rem_i.pop_front();
    end else begin
      m_we_v = 0;
      if (xfer && in_wb_en) begin
        m_rg = in_rd;
        if (!in_is_vec) begin
          m_we_c = 1;
          m_dinc = in_sel_mem ? in_mem_res : in_alu_res;
        end else begin
          m_wbrd = in_rd;
          m_we_v = 1;
          m_dinv = in_vec_res[7:0];
          m_lane = 0;
          for (int i = 1; i < int'(LANES); i++) begin
            rem_d.push_back(in_vec_res[i*8 +: 8]);
            rem_i.push_back(i);
          end
        end
      end
    end
  endtask

  // One clock: check model at negedge, advance model at posedge, return 1 time unit after the edge.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic v, input logic en, input logic isv, input logic sel,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [39:0] vec, input logic [3:0] rd);
    in_valid = v; in_wb_en = en; in_is_vec = isv; in_sel_mem = sel;
    in_alu_res = alu; in_mem_res = mem; in_vec_res = vec; in_rd = rd;
  endtask

  typedef struct {
    logic        valid;
    logic        wb_en;
    logic        is_vec;
    logic        sel;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [3:0]  rd;
    logic        e_we_c;
    logic [31:0] e_dinc;
    logic [3:0]  e_rg;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] e_lane;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h0,        4'd3,  1'b1, 32'h12345678, 4'd3};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h00000001, 32'hDEADBEEF, 4'd9,  1'b1, 32'hDEADBEEF, 4'd9};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000055, 32'h0,        4'd4,  1'b0, 32'hDEADBEEF, 4'd9};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00000066, 32'h0,        4'd5,  1'b0, 32'hDEADBEEF, 4'd9};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000077, 32'h0,        4'd6,  1'b0, 32'hDEADBEEF, 4'd9};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        4'd15, 1'b1, 32'hFFFFFFFF, 4'd15};

    // Reset state.
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_we_c", 64'(WE_C), 64'd0);
    check("rst_we_v", 64'(WE_V), 64'd0);
    check("rst_busy", 64'(wb_busy), 64'd0);
    check("rst_dinc", 64'(DinC), 64'd0);
    check("rst_rg", 64'(Rg_WB), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Scalar and bubble table.
    for (int i = 0; i < 6; i++) begin
      set_in(tbl[i].valid, tbl[i].wb_en, tbl[i].is_vec, tbl[i].sel, tbl[i].alu, tbl[i].mem,
             40'hFFEEDDCCBB, tbl[i].rd);
      check($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'd1);
      tick();
      check($sformatf("tbl%0d_we_c", i), 64'(WE_C), 64'(tbl[i].e_we_c));
      check($sformatf("tbl%0d_dinc", i), 64'(DinC), 64'(tbl[i].e_dinc));
      check($sformatf("tbl%0d_rg", i), 64'(Rg_WB), 64'(tbl[i].e_rg));
      check($sformatf("tbl%0d_we_v", i), 64'(WE_V), 64'd0);
      check($sformatf("tbl%0d_busy", i), 64'(wb_busy), 64'd0);
    end
    in_valid = 0;
    tick();

    // Vector serialisation.
    set_in(1, 1, 1, 0, 0, 0, 40'h5544332211, 4'd7);
    tick();
    in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      e_lane = 8'((k + 1) * 17);
      check($sformatf("vec_we_v%0d", k), 64'(WE_V), 64'd1);
      check($sformatf("vec_data%0d", k), 64'(DinV_8bit), 64'(e_lane));
      check($sformatf("vec_idx%0d", k), 64'(lane_idx), 64'(k));
      check($sformatf("vec_rg%0d", k), 64'(Rg_WB), 64'd7);
      check($sformatf("vec_busy%0d", k), 64'(wb_busy), 64'd1);
      check($sformatf("vec_ready%0d", k), 64'(in_ready), 64'(k == 4));
      tick();
    end
    check("vec_done_we_v", 64'(WE_V), 64'd0);
    check("vec_done_busy", 64'(wb_busy), 64'd0);

    // Back-to-back: scalar held valid during a vector, accepted in the last-lane cycle.
    set_in(1, 1, 1, 0, 0, 0, 40'hA1B2C3D4E5, 4'd5);
    tick();
    set_in(1, 1, 0, 1, 32'h0, 32'hCAFEF00D, 40'h0, 4'd2);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("b2b_we_c%0d", k), 64'(WE_C), 64'd0);
      check($sformatf("b2b_ready%0d", k), 64'(in_ready), 64'(k == 4));
      tick();
    end
    check("b2b_we_c", 64'(WE_C), 64'd1);
    check("b2b_dinc", 64'(DinC), 64'hCAFEF00D);
    check("b2b_rg", 64'(Rg_WB), 64'd2);
    check("b2b_we_v", 64'(WE_V), 64'd0);
    in_valid = 0;
    tick();

    // Reset in the middle of a vector.
    set_in(1, 1, 1, 0, 0, 0, 40'h0102030405, 4'd9);
    tick();
    in_valid = 0;
    tick();
    check("mid_pre_idx", 64'(lane_idx), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_we_v", 64'(WE_V), 64'd0);
    check("mid_dinv", 64'(DinV_8bit), 64'd0);
    check("mid_idx", 64'(lane_idx), 64'd0);
    check("mid_busy", 64'(wb_busy), 64'd0);
    check("mid_rg", 64'(Rg_WB), 64'd0);
    check("mid_wbrd", 64'(wb_rd), 64'd0);
    check("mid_dinc", 64'(DinC), 64'd0);
    check("mid_we_c", 64'(WE_C), 64'd0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("mid_nolane%0d", k), 64'(WE_V), 64'd0);
      tick();
    end

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom(), $urandom(),
             40'({$urandom(), $urandom()}), 4'($urandom_range(0, 15)));
      tick();
    end
    in_valid = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final stage of the image-filter processor pipeline: it takes completed scalar (32-bit) and vector (5 × 8-bit lanes) results and drives the register-file write ports that Decode reads from. Scalar results are written in one cycle. Vector results are serialised one lane per cycle onto the 8-bit vector write port, and the unit back-pressures the Memory stage while it does so. It also publishes a pending-write indication so Decode can stall on read-after-write hazards.

## Interface
Parameters:
- LANES, 5, vector lanes per vector register
- LANE_W, 8, bits per lane
- DATA_W, 32, scalar width
- REG_W, 4, register index width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  Memory stage presents a result
- in_ready  out  1  unit accepts the result this cycle
- in_wb_en  in  1  result must be written (0 = bubble or store)
- in_is_vec  in  1  1 = vector result, 0 = scalar result
- in_sel_mem  in  1  scalar source select: 1 = in_mem_res, 0 = in_alu_res
- in_alu_res  in  DATA_W  scalar ALU result
- in_mem_res  in  DATA_W  scalar load data
- in_vec_res  in  LANES*LANE_W  vector result, lane 0 in bits [7:0]
- in_rd  in  REG_W  destination register
- Rg_WB  out  REG_W  write address for both register files
- DinC  out  DATA_W  scalar write data
- WE_C  out  1  scalar write enable
- DinV_8bit  out  LANE_W  vector lane write data
- WE_V  out  1  vector lane write enable
- lane_idx  out  3  lane being written when WE_V = 1
- wb_busy  out  1  vector serialisation in progress
- wb_rd  out  REG_W  destination of the in-flight vector write (valid when wb_busy = 1)

## Operation
- Handshake: a transfer occurs on a rising clk edge when in_valid and in_ready are both 1. in_ready is combinational: 1 in IDLE, or in VEC when the current lane = LANES-1. Otherwise it is 0.
- FSM has two states, IDLE and VEC.
- Scalar accept (in_is_vec = 0): on the next cycle, WE_C = in_wb_en, DinC = the selected source, Rg_WB = in_rd. WE_C lasts one cycle. State stays IDLE.
- Vector accept with in_wb_en = 1: latch in_vec_res and in_rd, then go to VEC with lane = 0. Each VEC cycle drives WE_V = 1, DinV_8bit = lane[lane], lane_idx = lane, Rg_WB = latched rd.
- Lanes are written in order 0 to LANES-1, one per cycle. After the last lane, go to IDLE, or accept a new result that cycle (back-to-back transfer).
- Vector accept with in_wb_en = 0: consumed as a bubble. No write, no VEC entry.
- WE_C and WE_V are never both 1 in the same cycle.
- All write outputs are registered. WE_C/WE_V are 0 in every cycle with no write. DinC/DinV_8bit hold their last values.
- wb_busy = (state == VEC). wb_rd = latched rd. Decode uses these to stall any read of wb_rd until wb_busy drops.
- Reset (asynchronous, at any time, including mid-vector):
  - state ← IDLE, lane ← 0
  - WE_C, WE_V, wb_busy, lane_idx, Rg_WB, wb_rd, DinC, DinV_8bit ← 0
  - lanes not yet written are abandoned; in_ready = 1 after reset deasserts.

## Timing
- Scalar latency: 1 cycle from transfer to the WE_C pulse. Throughput is 1 per cycle.
- Vector latency: first lane 1 cycle after transfer, last lane LANES cycles after transfer. Throughput is one vector per LANES cycles.
- Back-to-back: a result accepted during the last-lane cycle has its first write in the very next cycle, with no idle gap.
- in_ready depends only on state and lane, never on in_valid (no combinational loop).

## Structure
- Shared package/header `proc_defs`: LANES, LANE_W, DATA_W, REG_W, and the FSM state encodings.
- Sub-module `lane_serializer`: holds the vector latch, the lane counter and the last-lane flag, and outputs DinV_8bit, lane_idx and WE_V.
- Top level holds the scalar mux/register, the handshake and the FSM.

## Test plan
- Scalar ALU: in_alu_res = 0x12345678, in_sel_mem = 0, in_rd = 3 → next cycle WE_C = 1, DinC = 0x12345678, Rg_WB = 3, WE_V = 0.
- Vector: in_vec_res = 0x5544332211, in_rd = 7 → 5 consecutive cycles with WE_V = 1, DinV_8bit = 11, 22, 33, 44, 55, lane_idx = 0 to 4, Rg_WB = 7. in_ready = 0 for the first 4 of those cycles. wb_busy = 1 throughout.
- Back-to-back: a vector, then a scalar (in_mem_res = 0xCAFEF00D, in_sel_mem = 1, rd = 2) held valid → the scalar is accepted in the lane-4 cycle, and the next cycle has WE_C = 1, DinC = 0xCAFEF00D, with no gap.
- Bubble: in_wb_en = 0 with in_is_vec = 1 → no WE_V, in_ready stays 1, wb_busy stays 0.
- Reset mid-vector: assert rst after lane 1 is written → WE_V = 0 immediately, all outputs 0, lanes 2–4 are never written, in_ready = 1 after release.
